// File: rtl/dram_traffic_initiator.sv
// AXI4 manager that writes a seeded pattern over a DRAM region, reads it back and
// compares, reporting a sticky error flag, an error count and the first failing address.

package dram_traffic_initiator_pkg;
    localparam int unsigned AxiAddrWidth = 48;
    localparam int unsigned AxiDataWidth = 64;
    localparam int unsigned AxiIdWidth   = 4;
    localparam int unsigned AxiUserWidth = 1;

    typedef struct packed {
        logic [AxiIdWidth-1:0]   id;
        logic [AxiAddrWidth-1:0] addr;
        logic [7:0]              len;
        logic [2:0]              size;
        logic [1:0]              burst;
        logic                    lock;
        logic [3:0]              cache;
        logic [2:0]              prot;
        logic [3:0]              qos;
        logic [3:0]              region;
        logic [AxiUserWidth-1:0] user;
    } axi_ax_chan_t;

    typedef struct packed {
        logic [AxiDataWidth-1:0]   data;
        logic [AxiDataWidth/8-1:0] strb;
        logic                      last;
        logic [AxiUserWidth-1:0]   user;
    } axi_w_chan_t;

    typedef struct packed {
        logic [AxiIdWidth-1:0]   id;
        logic [1:0]              resp;
        logic [AxiUserWidth-1:0] user;
    } axi_b_chan_t;

    typedef struct packed {
        logic [AxiIdWidth-1:0]   id;
        logic [AxiDataWidth-1:0] data;
        logic [1:0]              resp;
        logic                    last;
        logic [AxiUserWidth-1:0] user;
    } axi_r_chan_t;

    typedef struct packed {
        axi_ax_chan_t aw;
        logic         aw_valid;
        axi_w_chan_t  w;
        logic         w_valid;
        logic         b_ready;
        axi_ax_chan_t ar;
        logic         ar_valid;
        logic         r_ready;
    } axi_req_t;

    typedef struct packed {
        logic        aw_ready;
        logic        ar_ready;
        logic        w_ready;
        logic        b_valid;
        axi_b_chan_t b;
        logic        r_valid;
        axi_r_chan_t r;
    } axi_rsp_t;
endpackage

module dram_traffic_initiator #(
    parameter int unsigned AddrWidth = 48,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned BurstLen  = 8,
    parameter int unsigned CntWidth  = 16,
    parameter type axi_req_t = dram_traffic_initiator_pkg::axi_req_t,
    parameter type axi_rsp_t = dram_traffic_initiator_pkg::axi_rsp_t
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [AddrWidth-1:0] base_addr_i,
    input  logic [CntWidth-1:0]  num_bursts_i,
    input  logic [31:0]          seed_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [CntWidth-1:0]  err_cnt_o,
    output logic [AddrWidth-1:0] first_err_addr_o,
    output axi_req_t             axi_req_o,
    input  axi_rsp_t             axi_rsp_i
);
    localparam int unsigned BeatW = (BurstLen > 1) ? $clog2(BurstLen) : 1;
    localparam logic [AddrWidth-1:0] BeatBytes  = AddrWidth'(DataWidth / 8);
    localparam logic [AddrWidth-1:0] BurstBytes = AddrWidth'(BurstLen * DataWidth / 8);
    localparam logic [BeatW-1:0]     LastBeat   = BeatW'(BurstLen - 1);
    localparam logic [BeatW-1:0]     BeatOne    = BeatW'(1);
    localparam logic [CntWidth-1:0]  CntOne     = CntWidth'(1);
    localparam logic [31:0]          BurstLen32 = 32'(BurstLen);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AW   = 3'd1;
    localparam logic [2:0] S_W    = 3'd2;
    localparam logic [2:0] S_B    = 3'd3;
    localparam logic [2:0] S_AR   = 3'd4;
    localparam logic [2:0] S_R    = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    logic [2:0]           r_state;
    logic [AddrWidth-1:0] r_base;
    logic [AddrWidth-1:0] r_burst_addr;
    logic [AddrWidth-1:0] r_first_err_addr;
    logic [CntWidth-1:0]  r_num_bursts;
    logic [CntWidth-1:0]  r_burst;
    logic [CntWidth-1:0]  r_err_cnt;
    logic [31:0]          r_seed;
    logic [31:0]          r_kbase;
    logic [BeatW-1:0]     r_beat;
    logic                 r_err;

    logic [31:0]          w_pat;
    logic [DataWidth-1:0] w_beat_data;
    logic [AddrWidth-1:0] w_beat_addr;
    logic [AddrWidth-1:0] w_err_addr;
    logic                 w_last_beat;
    logic                 w_last_burst;
    logic                 w_r_end;
    logic                 w_err_evt;
    logic                 w_unused_rsp;
    axi_req_t             w_req;

    // r_kbase is the global beat index of the current burst's first beat
    assign w_pat        = r_seed + r_kbase + 32'(r_beat);
    assign w_beat_data  = {(DataWidth/32){w_pat}};
    assign w_beat_addr  = r_burst_addr + AddrWidth'(r_beat) * BeatBytes;
    assign w_last_beat  = (r_beat == LastBeat);
    assign w_last_burst = (r_burst == r_num_bursts - CntOne);
    assign w_r_end      = axi_rsp_i.r.last || w_last_beat;
    assign w_unused_rsp = ^{axi_rsp_i.b.id, axi_rsp_i.b.user, axi_rsp_i.r.id, axi_rsp_i.r.user};

    always_comb begin
        w_err_evt  = 1'b0;
        w_err_addr = r_burst_addr;
        if (r_state == S_B && axi_rsp_i.b_valid) begin
            w_err_evt = (axi_rsp_i.b.resp != 2'b00);
        end else if (r_state == S_R && axi_rsp_i.r_valid) begin
            w_err_evt  = (axi_rsp_i.r.data != w_beat_data) || (axi_rsp_i.r.resp != 2'b00) ||
                         (axi_rsp_i.r.last != w_last_beat);
            w_err_addr = w_beat_addr;
        end
    end

    always_comb begin
        w_req          = '0;
        w_req.aw.addr  = r_burst_addr;
        w_req.aw.len   = 8'(BurstLen - 1);
        w_req.aw.size  = 3'($clog2(DataWidth / 8));
        w_req.aw.burst = 2'b01;
        w_req.aw.cache = 4'b0011;
        w_req.aw_valid = (r_state == S_AW);
        w_req.w.data   = w_beat_data;
        w_req.w.strb   = '1;
        w_req.w.last   = w_last_beat;
        w_req.w_valid  = (r_state == S_W);
        w_req.b_ready  = (r_state == S_B);
        w_req.ar.addr  = r_burst_addr;
        w_req.ar.len   = 8'(BurstLen - 1);
        w_req.ar.size  = 3'($clog2(DataWidth / 8));
        w_req.ar.burst = 2'b01;
        w_req.ar.cache = 4'b0011;
        w_req.ar_valid = (r_state == S_AR);
        w_req.r_ready  = (r_state == S_R);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state          <= S_IDLE;
            r_base           <= '0;
            r_burst_addr     <= '0;
            r_first_err_addr <= '0;
            r_num_bursts     <= '0;
            r_burst          <= '0;
            r_err_cnt        <= '0;
            r_seed           <= '0;
            r_kbase          <= '0;
            r_beat           <= '0;
            r_err            <= 1'b0;
        end else begin
            if (w_err_evt) begin
                r_err <= 1'b1;
                if (!r_err) r_first_err_addr <= w_err_addr;
                if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + CntOne;
            end
            case (r_state)
                S_IDLE: if (start_i) begin
                    r_base           <= base_addr_i;
                    r_burst_addr     <= base_addr_i;
                    r_num_bursts     <= num_bursts_i;
                    r_seed           <= seed_i;
                    r_burst          <= '0;
                    r_beat           <= '0;
                    r_kbase          <= '0;
                    r_err            <= 1'b0;
                    r_err_cnt        <= '0;
                    r_first_err_addr <= '0;
                    r_state          <= (num_bursts_i == '0) ? S_DONE : S_AW;
                end
                S_AW: if (axi_rsp_i.aw_ready) r_state <= S_W;
                S_W: if (axi_rsp_i.w_ready) begin
                    if (w_last_beat) begin
                        r_beat  <= '0;
                        r_kbase <= r_kbase + BurstLen32;
                        r_state <= S_B;
                    end else begin
                        r_beat <= r_beat + BeatOne;
                    end
                end
                S_B: if (axi_rsp_i.b_valid) begin
                    if (w_last_burst) begin
                        r_burst      <= '0;
                        r_kbase      <= '0;
                        r_burst_addr <= r_base;
                        r_state      <= S_AR;
                    end else begin
                        r_burst      <= r_burst + CntOne;
                        r_burst_addr <= r_burst_addr + BurstBytes;
                        r_state      <= S_AW;
                    end
                end
                S_AR: if (axi_rsp_i.ar_ready) r_state <= S_R;
                // An early r.last still closes the burst so later bursts stay aligned
                S_R: if (axi_rsp_i.r_valid) begin
                    if (w_r_end) begin
                        r_beat  <= '0;
                        r_kbase <= r_kbase + BurstLen32;
                        if (w_last_burst) begin
                            r_state <= S_DONE;
                        end else begin
                            r_burst      <= r_burst + CntOne;
                            r_burst_addr <= r_burst_addr + BurstBytes;
                            r_state      <= S_AR;
                        end
                    end else begin
                        r_beat <= r_beat + BeatOne;
                    end
                end
                S_DONE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy_o           = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done_o           = (r_state == S_DONE);
    assign err_o            = r_err;
    assign err_cnt_o        = r_err_cnt;
    assign first_err_addr_o = r_first_err_addr;
    assign axi_req_o        = w_req;
endmodule

// File: tb/tb_dram_traffic_initiator.sv
// Directed bench for dram_traffic_initiator with a reactive AXI memory subordinate
// (optional stalls, read bit-flip and B error injection).
module tb_dram_traffic_initiator;
    import dram_traffic_initiator_pkg::*;

    localparam int BL = 8;
    localparam logic [47:0] BASE = 48'h0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [47:0] base_addr_i = '0;
    logic [15:0] num_bursts_i = '0;
    logic [31:0] seed_i = '0;
    logic        busy_o, done_o, err_o;
    logic [15:0] err_cnt_o;
    logic [47:0] first_err_addr_o;
    axi_req_t    req;
    axi_rsp_t    rsp;

    int checks = 0;
    int errors = 0;

    // subordinate configuration (written only by the test sequence)
    bit stall_en = 0;
    int flip_idx = -1;
    int bresp_err_burst = -1;

    dram_traffic_initiator #(
        .AddrWidth(48), .DataWidth(64), .BurstLen(BL), .CntWidth(16)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .base_addr_i(base_addr_i),
        .num_bursts_i(num_bursts_i), .seed_i(seed_i), .busy_o(busy_o), .done_o(done_o),
        .err_o(err_o), .err_cnt_o(err_cnt_o), .first_err_addr_o(first_err_addr_o),
        .axi_req_o(req), .axi_rsp_i(rsp)
    );

    always #5 clk = ~clk;

    // memory subordinate: updates at negedge, handshakes complete at the posedge between
    logic [63:0]  mem [0:63];
    int unsigned  w_count = 0, valid_cycles = 0, stab_err = 0;
    bit           aw_hs, w_hs, b_hs, ar_hs, r_hs;
    bit           wr_active, rd_active, b_pend;
    int           b_delay;
    int unsigned  wbeat, rbeat;
    logic [47:0]  wr_addr, rd_addr;
    axi_req_t     prev_req;
    axi_ax_chan_t last_aw, last_ar;
    axi_w_chan_t  last_w;

    function automatic int idx(input logic [47:0] a);
        return int'((a - BASE) >> 3);
    endfunction

    function automatic bit rnd_ok();
        return stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    endfunction

    always @(negedge clk) begin
        if (rst_i) begin
            rsp = '0;
            {aw_hs, w_hs, b_hs, ar_hs, r_hs} = '0;
            {wr_active, rd_active, b_pend} = '0;
            prev_req = '0;
        end else begin
            if (prev_req.aw_valid && !aw_hs && (!req.aw_valid || req.aw !== prev_req.aw)) stab_err++;
            if (prev_req.w_valid && !w_hs && (!req.w_valid || req.w !== prev_req.w)) stab_err++;
            if (prev_req.ar_valid && !ar_hs && (!req.ar_valid || req.ar !== prev_req.ar)) stab_err++;
            if (aw_hs) begin wr_addr = prev_req.aw.addr; wbeat = 0; wr_active = 1; last_aw = prev_req.aw; end
            if (w_hs) begin
                mem[idx(wr_addr) + int'(wbeat)] = prev_req.w.data;
                last_w = prev_req.w;
                w_count++;
                wbeat++;
                if (prev_req.w.last) begin
                    wr_active = 0;
                    b_pend = 1;
                    b_delay = stall_en ? int'($urandom_range(0, 20)) : 0;
                end
            end
            if (b_hs) rsp.b_valid = 1'b0;
            if (ar_hs) begin rd_addr = prev_req.ar.addr; rbeat = 0; rd_active = 1; last_ar = prev_req.ar; end
            if (r_hs) begin
                rsp.r_valid = 1'b0;
                rbeat++;
                if (rbeat == BL) rd_active = 0;
            end
            rsp.aw_ready = rnd_ok();
            rsp.ar_ready = rnd_ok();
            rsp.w_ready  = wr_active && rnd_ok();
            if (b_pend) begin
                if (b_delay == 0) begin
                    rsp.b_valid = 1'b1;
                    rsp.b.resp  = (idx(wr_addr) / BL == bresp_err_burst) ? 2'b10 : 2'b00;
                    b_pend = 0;
                end else begin
                    b_delay--;
                end
            end
            if (rd_active && !rsp.r_valid && rnd_ok()) begin
                automatic int k = idx(rd_addr) + int'(rbeat);
                rsp.r_valid = 1'b1;
                rsp.r.data  = mem[k] ^ ((k == flip_idx) ? 64'h8 : 64'h0);
                rsp.r.last  = (rbeat == BL - 1);
                rsp.r.resp  = 2'b00;
            end
            aw_hs = req.aw_valid && rsp.aw_ready;
            w_hs  = req.w_valid && rsp.w_ready;
            b_hs  = rsp.b_valid && req.b_ready;
            ar_hs = req.ar_valid && rsp.ar_ready;
            r_hs  = rsp.r_valid && req.r_ready;
            if (req.aw_valid || req.w_valid || req.ar_valid) valid_cycles++;
            prev_req = req;
        end
    end

    task automatic start_run(input logic [47:0] b, input logic [15:0] n, input logic [31:0] s);
        @(negedge clk);
        base_addr_i = b; num_bursts_i = n; seed_i = s; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int i = 0; i < 4000; i++) begin
            if (done_o) begin cyc = i; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if ({busy_o, done_o, err_o} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {busy_o, done_o, err_o}); end
        checks++; if (err_cnt_o !== 16'd0 || first_err_addr_o !== 48'd0) begin errors++; $display("FAIL reset_err_regs: got cnt=%0d addr=%h expected 0/0", err_cnt_o, first_err_addr_o); end
        checks++; if ({req.aw_valid, req.w_valid, req.ar_valid, req.b_ready, req.r_ready} !== 5'b0) begin errors++; $display("FAIL reset_axi: got %b expected 00000", {req.aw_valid, req.w_valid, req.ar_valid, req.b_ready, req.r_ready}); end
        rst_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ideal();
        int cyc; int unsigned w0 = w_count;
        start_run(BASE, 16'd4, 32'h1000);
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL ideal_busy: got %b expected 1", busy_o); end
        wait_done(cyc);
        checks++; if (cyc < 0) begin errors++; $display("FAIL ideal_done: got timeout expected done pulse"); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL ideal_busy_at_done: got %b expected 0", busy_o); end
        checks++; if (w_count - w0 !== 32) begin errors++; $display("FAIL ideal_writes: got %0d expected 32", w_count - w0); end
        checks++; if (mem[0] !== 64'h00001000_00001000) begin errors++; $display("FAIL ideal_beat0: got %h expected 0000100000001000", mem[0]); end
        checks++; if (mem[31] !== 64'h0000101F_0000101F) begin errors++; $display("FAIL ideal_beat31: got %h expected 0000101f0000101f", mem[31]); end
        checks++; if (err_o !== 1'b0 || err_cnt_o !== 16'd0) begin errors++; $display("FAIL ideal_err: got err=%b cnt=%0d expected 0/0", err_o, err_cnt_o); end
        checks++; if (last_aw.addr !== 48'h0000_8000_00C0 || last_ar.addr !== 48'h0000_8000_00C0) begin errors++; $display("FAIL ideal_last_addr: got aw=%h ar=%h expected 0000800000c0", last_aw.addr, last_ar.addr); end
        checks++; if ({last_aw.len, last_aw.size, last_aw.burst, last_aw.cache} !== {8'd7, 3'd3, 2'b01, 4'b0011}) begin errors++; $display("FAIL ideal_aw_fields: got len=%0d size=%0d burst=%0d cache=%h expected 7/3/1/3", last_aw.len, last_aw.size, last_aw.burst, last_aw.cache); end
        checks++; if (last_w.strb !== 8'hFF) begin errors++; $display("FAIL ideal_strb: got %h expected ff", last_w.strb); end
        @(negedge clk);
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL ideal_done_pulse: got %b expected 0", done_o); end
    endtask

    task automatic test_bitflip();
        int cyc;
        flip_idx = 5;
        start_run(BASE, 16'd4, 32'h1000);
        wait_done(cyc);
        flip_idx = -1;
        checks++; if (cyc < 0) begin errors++; $display("FAIL flip_done: got timeout expected done pulse"); end
        checks++; if (err_o !== 1'b1 || err_cnt_o !== 16'd1) begin errors++; $display("FAIL flip_err: got err=%b cnt=%0d expected 1/1", err_o, err_cnt_o); end
        checks++; if (first_err_addr_o !== 48'h0000_8000_0028) begin errors++; $display("FAIL flip_addr: got %h expected 000080000028", first_err_addr_o); end
    endtask

    task automatic test_zero_bursts();
        int unsigned v0 = valid_cycles;
        start_run(BASE, 16'd0, 32'h55);
        checks++; if (done_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL zero_done: got done=%b busy=%b expected 1/0", done_o, busy_o); end
        checks++; if (err_o !== 1'b0 || err_cnt_o !== 16'd0 || first_err_addr_o !== 48'd0) begin errors++; $display("FAIL zero_cleared: got err=%b cnt=%0d addr=%h expected 0/0/0", err_o, err_cnt_o, first_err_addr_o); end
        repeat (4) @(negedge clk);
        checks++; if (valid_cycles - v0 !== 0) begin errors++; $display("FAIL zero_no_valid: got %0d valid cycles expected 0", valid_cycles - v0); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL zero_done_pulse: got %b expected 0", done_o); end
    endtask

    task automatic test_stalls();
        int cyc; int bad = 0; int unsigned w0 = w_count, s0 = stab_err;
        stall_en = 1;
        start_run(BASE, 16'd4, 32'h1000);
        wait_done(cyc);
        stall_en = 0;
        checks++; if (cyc < 0) begin errors++; $display("FAIL stall_done: got timeout expected done pulse"); end
        checks++; if (stab_err - s0 !== 0) begin errors++; $display("FAIL stall_stable: got %0d violations expected 0", stab_err - s0); end
        checks++; if (w_count - w0 !== 32) begin errors++; $display("FAIL stall_writes: got %0d expected 32", w_count - w0); end
        for (int k = 0; k < 32; k++) if (mem[k] !== {2{32'h1000 + 32'(k)}}) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL stall_mem: got %0d bad words expected 0", bad); end
        checks++; if (err_o !== 1'b0 || err_cnt_o !== 16'd0) begin errors++; $display("FAIL stall_err: got err=%b cnt=%0d expected 0/0", err_o, err_cnt_o); end
    endtask

    task automatic test_bresp_error();
        int cyc = -1; int unsigned w0 = w_count;
        bresp_err_burst = 2;
        start_run(BASE, 16'd4, 32'h1000);
        for (int i = 0; i < 4000; i++) begin
            if (done_o) begin cyc = i; break; end
            if (i == 10) begin base_addr_i = BASE + 48'h400; num_bursts_i = 16'd1; seed_i = 32'hDEAD; start_i = 1'b1; end
            if (i == 11) start_i = 1'b0;
            @(negedge clk);
        end
        start_i = 1'b0;
        bresp_err_burst = -1;
        checks++; if (cyc < 0) begin errors++; $display("FAIL bresp_done: got timeout expected done pulse"); end
        checks++; if (err_o !== 1'b1 || err_cnt_o !== 16'd1) begin errors++; $display("FAIL bresp_err: got err=%b cnt=%0d expected 1/1", err_o, err_cnt_o); end
        checks++; if (first_err_addr_o !== 48'h0000_8000_0080) begin errors++; $display("FAIL bresp_addr: got %h expected 000080000080", first_err_addr_o); end
        checks++; if (w_count - w0 !== 32) begin errors++; $display("FAIL bresp_ignore_start: got %0d writes expected 32", w_count - w0); end
    endtask

    task automatic test_reset_during_w();
        int cyc = -1; int unsigned w0;
        start_run(BASE, 16'd4, 32'h2000);
        for (int i = 0; i < 200; i++) begin
            if (req.w_valid) begin cyc = i; break; end
            @(negedge clk);
        end
        checks++; if (cyc < 0) begin errors++; $display("FAIL rstw_reach_w: got timeout expected w_valid"); end
        rst_i = 1'b1;
        @(negedge clk);
        checks++; if ({req.aw_valid, req.w_valid, req.ar_valid, req.b_ready, req.r_ready, busy_o} !== 6'b0) begin errors++; $display("FAIL rstw_drop: got %b expected 000000", {req.aw_valid, req.w_valid, req.ar_valid, req.b_ready, req.r_ready, busy_o}); end
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        w0 = w_count;
        start_run(BASE, 16'd4, 32'h1000);
        wait_done(cyc);
        checks++; if (cyc < 0) begin errors++; $display("FAIL rstw_rerun_done: got timeout expected done pulse"); end
        checks++; if (err_o !== 1'b0 || err_cnt_o !== 16'd0 || w_count - w0 !== 32) begin errors++; $display("FAIL rstw_rerun: got err=%b cnt=%0d writes=%0d expected 0/0/32", err_o, err_cnt_o, w_count - w0); end
    endtask

    initial begin
        test_reset();
        test_ideal();
        test_bitflip();
        test_zero_bursts();
        test_stalls();
        test_bresp_error();
        test_reset_during_w();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
